// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues single-word memory reads, holds the returned word
// in an instruction register until consumed, and handles control-flow redirects.
module fetch_unit #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 16,
    parameter int RESET_PC = 0,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              ir_ready,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    output logic [ADDR_W-1:0] ir_pc,
    output logic [ADDR_W-1:0] pc,
    output logic [CNT_W-1:0]  fetch_count
);

    typedef enum logic [1:0] {START, FETCH, DISCARD, HOLD} state_t;

    localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

    state_t state;

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values; blocking here would make pc+1 and ir_pc<=pc race.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= START;
            pc          <= RESET_ADDR;
            mem_req     <= 1'b0;
            mem_addr    <= RESET_ADDR;
            ir          <= '0;
            ir_pc       <= '0;
            ir_valid    <= 1'b0;
            fetch_count <= '0;
        end else begin
            case (state)
                START: begin
                    mem_req  <= 1'b1;
                    mem_addr <= pc;
                    state    <= FETCH;
                end

                // FETCH entered with mem_req=0 spends one idle cycle before
                // issuing, which provides the mandatory gap after every ack.
                FETCH: begin
                    if (!mem_req) begin
                        mem_req <= 1'b1;
                        if (jump_en) begin
                            pc       <= jump_addr;
                            mem_addr <= jump_addr;
                        end else begin
                            mem_addr <= pc;
                        end
                    end else if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (jump_en) begin
                            pc <= jump_addr;
                        end else begin
                            ir       <= mem_rdata;
                            ir_pc    <= pc;
                            ir_valid <= 1'b1;
                            pc       <= pc + ADDR_W'(1);
                            state    <= HOLD;
                        end
                    end else if (jump_en) begin
                        pc    <= jump_addr;
                        state <= DISCARD;
                    end
                end

                // The stale request is still outstanding; wait for its ack and
                // throw the data away.
                DISCARD: begin
                    if (jump_en) begin
                        pc <= jump_addr;
                    end
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= FETCH;
                    end
                end

                HOLD: begin
                    if (ir_ready || jump_en) begin
                        ir_valid <= 1'b0;
                        state    <= FETCH;
                        if (jump_en) begin
                            pc <= jump_addr;
                        end
                        if (ir_ready && fetch_count != CNT_MAX) begin
                            fetch_count <= fetch_count + CNT_W'(1);
                        end
                    end
                end

                default: state <= START;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; a second instance with a 2-bit counter shares
// all inputs to exercise counter saturation.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        jump_en;
    logic [7:0]  jump_addr;
    logic        ir_ready;

    logic        mem_req;
    logic [7:0]  mem_addr;
    logic [15:0] ir;
    logic        ir_valid;
    logic [7:0]  ir_pc;
    logic [7:0]  pc;
    logic [15:0] fetch_count;

    logic        mem_req_s;
    logic [7:0]  mem_addr_s;
    logic [15:0] ir_s;
    logic        ir_valid_s;
    logic [7:0]  ir_pc_s;
    logic [7:0]  pc_s;
    logic [1:0]  fetch_count_s;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_ack_cyc;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .jump_en(jump_en),
        .jump_addr(jump_addr), .ir_ready(ir_ready), .ir(ir),
        .ir_valid(ir_valid), .ir_pc(ir_pc), .pc(pc), .fetch_count(fetch_count)
    );

    fetch_unit #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .mem_req(mem_req_s), .mem_addr(mem_addr_s),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .jump_en(jump_en),
        .jump_addr(jump_addr), .ir_ready(ir_ready), .ir(ir_s),
        .ir_valid(ir_valid_s), .ir_pc(ir_pc_s), .pc(pc_s),
        .fetch_count(fetch_count_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Waits (bounded) for a request, checks its address, then acks for one cycle.
    task automatic fetch_ack(input string tag, input logic [7:0] exp_addr, input logic [15:0] data);
        for (int n = 0; n < 16 && mem_req !== 1'b1; n++) step();
        check({tag, "_req"}, 32'(mem_req), 32'd1);
        check({tag, "_addr"}, 32'(mem_addr), 32'(exp_addr));
        mem_ack   = 1'b1;
        mem_rdata = data;
        step();
        last_ack_cyc = cyc;
        mem_ack = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        jump_en   = 1'b0;
        jump_addr = '0;
        ir_ready  = 1'b1;
        #2 rst = 1'b0;
        step();
        step();

        // Reset state
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_ir", 32'(ir), 32'd0);
        check("rst_ir_pc", 32'(ir_pc), 32'd0);
        check("rst_ir_valid", 32'(ir_valid), 32'd0);
        check("rst_count", 32'(fetch_count), 32'd0);

        // START lasts one cycle, then the first request appears at RESET_PC
        rst = 1'b1;
        step();
        check("start_req", 32'(mem_req), 32'd1);
        check("start_addr", 32'(mem_addr), 32'd0);

        // Three fetches returning addr*3, accepted at once; one per 3 cycles
        for (int i = 0; i < 3; i++) begin
            int prev_ack;
            prev_ack = last_ack_cyc;
            fetch_ack("seq", 8'(i), 16'(i * 3));
            if (i > 0) check("throughput", 32'(last_ack_cyc - prev_ack), 32'd3);
            check("seq_ir", 32'(ir), 32'(i * 3));
            check("seq_ir_pc", 32'(ir_pc), 32'(i));
            check("seq_ir_valid", 32'(ir_valid), 32'd1);
            check("seq_gap", 32'(mem_req), 32'd0);
            step();
            check("seq_accept_valid", 32'(ir_valid), 32'd0);
            check("seq_count", 32'(fetch_count), 32'(i + 1));
        end

        // Consumer stalls for 10 cycles in HOLD
        ir_ready = 1'b0;
        fetch_ack("stall", 8'h03, 16'hA5A5);
        for (int i = 0; i < 10; i++) begin
            step();
            check("stall_req", 32'(mem_req), 32'd0);
            check("stall_valid", 32'(ir_valid), 32'd1);
        end
        check("stall_ir", 32'(ir), 32'hA5A5);
        check("stall_ir_pc", 32'(ir_pc), 32'h03);
        check("stall_count", 32'(fetch_count), 32'd3);
        ir_ready = 1'b1;
        step();
        check("stall_release", 32'(fetch_count), 32'd4);
        fetch_ack("fifth", 8'h04, 16'h1111);
        step();
        check("count5", 32'(fetch_count), 32'd5);
        check("sat_count", 32'(fetch_count_s), 32'd3);

        // Jump two cycles into a 4-cycle-latency fetch at 0x05
        for (int n = 0; n < 16 && mem_req !== 1'b1; n++) step();
        check("lat_addr", 32'(mem_addr), 32'h05);
        step();
        jump_en   = 1'b1;
        jump_addr = 8'h40;
        step();
        jump_en = 1'b0;
        check("disc_pc", 32'(pc), 32'h40);
        check("disc_req_held", 32'(mem_req), 32'd1);
        check("disc_addr_held", 32'(mem_addr), 32'h05);
        step();
        mem_ack   = 1'b1;
        mem_rdata = 16'hDEAD;
        step();
        mem_ack = 1'b0;
        check("disc_valid", 32'(ir_valid), 32'd0);
        check("disc_ir", 32'(ir), 32'h1111);
        check("disc_gap", 32'(mem_req), 32'd0);
        step();
        check("disc_next_req", 32'(mem_req), 32'd1);
        check("disc_next_addr", 32'(mem_addr), 32'h40);

        // Jump and ack in the same FETCH cycle
        fetch_ack("j40", 8'h40, 16'h4040);
        step();
        for (int n = 0; n < 16 && mem_req !== 1'b1; n++) step();
        check("jack_addr", 32'(mem_addr), 32'h41);
        mem_ack   = 1'b1;
        mem_rdata = 16'hBAD0;
        jump_en   = 1'b1;
        jump_addr = 8'h20;
        step();
        mem_ack = 1'b0;
        jump_en = 1'b0;
        check("jack_ir", 32'(ir), 32'h4040);
        check("jack_valid", 32'(ir_valid), 32'd0);
        check("jack_gap", 32'(mem_req), 32'd0);
        step();
        check("jack_req", 32'(mem_req), 32'd1);
        check("jack_addr_new", 32'(mem_addr), 32'h20);
        check("jack_count", 32'(fetch_count), 32'd6);

        // Jump in HOLD together with an accept, to 0xFF, then wrap
        fetch_ack("j20", 8'h20, 16'h2020);
        jump_en   = 1'b1;
        jump_addr = 8'hFF;
        step();
        jump_en = 1'b0;
        check("hjump_valid", 32'(ir_valid), 32'd0);
        check("hjump_pc", 32'(pc), 32'hFF);
        check("hjump_count", 32'(fetch_count), 32'd7);
        fetch_ack("wrap", 8'hFF, 16'h1234);
        check("wrap_ir_pc", 32'(ir_pc), 32'hFF);
        check("wrap_pc", 32'(pc), 32'h00);
        step();
        step();
        check("wrap_next_addr", 32'(mem_addr), 32'h00);

        // Reset during DISCARD with a late ack pending
        jump_en   = 1'b1;
        jump_addr = 8'h77;
        step();
        jump_en = 1'b0;
        rst     = 1'b0;
        mem_ack = 1'b1;
        #1;
        check("mid_rst_req", 32'(mem_req), 32'd0);
        check("mid_rst_pc", 32'(pc), 32'd0);
        check("mid_rst_ir", 32'(ir), 32'd0);
        check("mid_rst_ir_pc", 32'(ir_pc), 32'd0);
        check("mid_rst_count", 32'(fetch_count), 32'd0);
        step();
        rst = 1'b1;
        step();
        mem_ack = 1'b0;
        check("rerst_valid", 32'(ir_valid), 32'd0);
        check("rerst_req", 32'(mem_req), 32'd1);
        check("rerst_addr", 32'(mem_addr), 32'd0);
        fetch_ack("rerst_fetch", 8'h00, 16'h0BEE);
        check("rerst_ir", 32'(ir), 32'h0BEE);
        check("rerst_ir_pc", 32'(ir_pc), 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, program/memory address width in bits.
REQ-002 The block SHALL have parameter DATA_W, default 16, instruction word width in bits.
REQ-003 The block SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 The block SHALL have parameter CNT_W, default 16, width of the retired-fetch counter.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1, asynchronous active-low reset; asserting it resets all state immediately.
REQ-007 The block SHALL have port mem_req, output, 1, instruction read request to memory.
REQ-008 The block SHALL have port mem_addr, output, ADDR_W, read address, valid while mem_req=1.
REQ-009 The block SHALL have port mem_ack, input, 1, memory completion strobe; mem_rdata is valid in the same cycle.
REQ-010 The block SHALL have port mem_rdata, input, DATA_W, instruction word returned by memory.
REQ-011 The block SHALL have port jump_en, input, 1, redirect request from the control unit.
REQ-012 The block SHALL have port jump_addr, input, ADDR_W, redirect target.
REQ-013 The block SHALL have port ir_ready, input, 1, consumer accepts the held instruction.
REQ-014 The block SHALL have port ir, output, DATA_W, instruction register contents.
REQ-015 The block SHALL have port ir_valid, output, 1, ir holds an unconsumed instruction.
REQ-016 The block SHALL have port ir_pc, output, ADDR_W, address from which ir was fetched.
REQ-017 The block SHALL have port pc, output, ADDR_W, next address to fetch.
REQ-018 The block SHALL have port fetch_count, output, CNT_W, count of instructions accepted by the consumer.

Function
REQ-019 The block SHALL implement a registered FSM with states START, FETCH, DISCARD and HOLD.
REQ-020 START SHALL last exactly one cycle after rst deasserts, then go to FETCH with mem_req=1 and mem_addr=pc.
REQ-021 In FETCH and DISCARD, mem_req SHALL stay 1 and mem_addr SHALL stay stable until the cycle mem_ack=1.
REQ-022 After every ack, mem_req SHALL be 0 for at least the following cycle.
REQ-023 FETCH with mem_ack=1 and jump_en=0 SHALL load ir<=mem_rdata, ir_pc<=pc, ir_valid<=1 and pc<=pc+1, then go to HOLD.
REQ-024 pc increment SHALL wrap modulo 2^ADDR_W (all-ones -> 0).
REQ-025 FETCH with jump_en=1 and mem_ack=0 SHALL load pc<=jump_addr and go to DISCARD, keeping the outstanding request unchanged.
REQ-026 DISCARD with mem_ack=1 SHALL drop mem_rdata, leave ir, ir_pc and ir_valid unchanged, and go to FETCH at the current pc.
REQ-027 A jump_en in DISCARD SHALL overwrite pc with the newest jump_addr; the state SHALL remain DISCARD.
REQ-028 FETCH with jump_en=1 and mem_ack=1 in the same cycle SHALL drop the data, load pc<=jump_addr, and go to FETCH after the one-cycle mem_req gap.
REQ-029 HOLD with ir_ready=1 and jump_en=0 SHALL clear ir_valid, increment fetch_count, and go to FETCH.
REQ-030 HOLD with jump_en=1 SHALL clear ir_valid, load pc<=jump_addr, and go to FETCH.
REQ-031 If ir_ready=1 in the same HOLD cycle as a jump, fetch_count SHALL also increment.
REQ-032 fetch_count SHALL saturate at 2^CNT_W-1.
REQ-033 ir and ir_pc SHALL change only on the REQ-023 load.
REQ-034 mem_ack in START or HOLD SHALL be ignored.
REQ-035 With a one-cycle ack and ir_ready held at 1, throughput SHALL be one instruction per 3 cycles.

Reset
REQ-036 While rst=0, the block SHALL hold state=START, pc=RESET_PC, mem_req=0, mem_addr=RESET_PC, ir=0, ir_pc=0, ir_valid=0 and fetch_count=0.
REQ-037 Reset asserted mid-request SHALL abandon the request; a late mem_ack SHALL be ignored until START completes.

Verification
REQ-038 Reset release, memory returning addr*3 with 1-cycle ack and ir_ready=1 -> ir=0,3,6 at ir_pc=0,1,2 and fetch_count=3 after three accepts.
REQ-039 pc=8'hFF in FETCH with ack -> ir_pc=8'hFF and pc=8'h00; next mem_addr=8'h00.
REQ-040 jump_en with jump_addr=8'h40 two cycles into a 4-cycle-latency fetch -> the old word is discarded, ir_valid stays 0, and the next mem_addr=8'h40.
REQ-041 jump_en with jump_addr=8'h20 and mem_ack in the same FETCH cycle -> no ir load, one cycle with mem_req=0, then mem_addr=8'h20.
REQ-042 ir_ready=0 for 10 cycles in HOLD -> ir, ir_pc and ir_valid are stable, mem_req=0, fetch_count unchanged; CNT_W=2 with 5 accepts -> fetch_count=3.
REQ-043 rst pulsed low during a DISCARD with a pending ack -> post-reset values per REQ-036, and the first fetch is at RESET_PC.
